// File: rtl/digit_serial_addsub_if.sv
// Streaming operand/result bundle for the digit-serial add/sub lane.
// master drives operands and out_ready; slave is the arithmetic block.
interface digit_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, op, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, op, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow, zero
    );
endinterface

// File: rtl/digit_serial_addsub.sv
// Digit-serial signed/unsigned adder-subtractor: DIGIT bits per clock, carry held between digits.
// Optional signed saturation is enabled by defining DIGIT_SERIAL_ADDSUB_SATURATE_EN.
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    digit_serial_addsub_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic             carry_q,     carry_d;
    logic [WIDTH-1:0] a_sh_q,      a_sh_d;
    logic [WIDTH-1:0] b_sh_q,      b_sh_d;
    logic [WIDTH-1:0] res_q,       res_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             cout_q,      cout_d;
    logic             ovf_q,       ovf_d;
    logic             zero_q,      zero_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [DIGIT-1:0] a_dig_s;
    logic [DIGIT-1:0] b_dig_s;
    logic [DIGIT:0]   dig_sum_s;
    logic [WIDTH-1:0] res_ins_s;
    logic             msb_cin_s;
    logic             ovf_fin_s;
    logic [WIDTH-1:0] fin_sum_s;

`ifdef DIGIT_SERIAL_ADDSUB_SATURATE_EN
    logic a_msb_q, a_msb_d;
`endif

    // One ripple slice on the low digit; result digits enter at the top and shift down.
    always_comb begin
        a_dig_s   = a_sh_q[DIGIT-1:0];
        b_dig_s   = b_sh_q[DIGIT-1:0];
        dig_sum_s = {1'b0, a_dig_s} + {1'b0, b_dig_s} + {{DIGIT{1'b0}}, carry_q};
        res_ins_s = (res_q >> DIGIT) | (WIDTH'(dig_sum_s[DIGIT-1:0]) << (WIDTH - DIGIT));
        // Only meaningful on the last digit, where bit DIGIT-1 is the operand MSB.
        msb_cin_s = a_dig_s[DIGIT-1] ^ b_dig_s[DIGIT-1] ^ dig_sum_s[DIGIT-1];
        ovf_fin_s = msb_cin_s ^ dig_sum_s[DIGIT];
`ifdef DIGIT_SERIAL_ADDSUB_SATURATE_EN
        if (ovf_fin_s) begin
            fin_sum_s = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            fin_sum_s = res_ins_s;
        end
`else
        fin_sum_s = res_ins_s;
`endif
    end

    // Control FSM and next-state for datapath and registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_d       = res_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef DIGIT_SERIAL_ADDSUB_SATURATE_EN
        a_msb_d     = a_msb_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    state_d    = ST_RUN;
                    cnt_d      = {CW{1'b0}};
                    a_sh_d     = bus.a;
                    b_sh_d     = bus.b ^ {WIDTH{bus.op}};
                    carry_d    = bus.cin ^ bus.op;
                    in_ready_d = 1'b0;
`ifdef DIGIT_SERIAL_ADDSUB_SATURATE_EN
                    a_msb_d    = bus.a[WIDTH-1];
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d  = a_sh_q >> DIGIT;
                b_sh_d  = b_sh_q >> DIGIT;
                res_d   = res_ins_s;
                carry_d = dig_sum_s[DIGIT];
                if (cnt_q == LAST_DIG) begin
                    state_d     = ST_DONE;
                    sum_d       = fin_sum_s;
                    cout_d      = dig_sum_s[DIGIT];
                    ovf_d       = ovf_fin_s;
                    zero_d      = (fin_sum_s == {WIDTH{1'b0}});
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and output registers; reset drops any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            carry_q     <= 1'b0;
            a_sh_q      <= {WIDTH{1'b0}};
            b_sh_q      <= {WIDTH{1'b0}};
            res_q       <= {WIDTH{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef DIGIT_SERIAL_ADDSUB_SATURATE_EN
            a_msb_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_q       <= res_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef DIGIT_SERIAL_ADDSUB_SATURATE_EN
            a_msb_q     <= a_msb_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_digit_serial_addsub.sv
// Scoreboard bench for digit_serial_addsub: three lanes (DIGIT = 4, 1, 16, WIDTH = 16)
// driven by directed and random operands, checked against an integer arithmetic model.
module tb_digit_serial_addsub;
    localparam int NL = 3;
    localparam int DIG [NL] = '{4, 1, 16};

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        overflow;
        logic        zero;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [NL-1:0] drv_iv, drv_op, drv_cin, drv_ordy;
    logic [15:0]   drv_a [NL];
    logic [15:0]   drv_b [NL];
    logic [NL-1:0] m_ir, m_ov, m_co, m_of, m_z;
    logic [15:0]   m_sum [NL];

    exp_t sb [NL][$];
    bit [NL-1:0] seen;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NL; g++) begin : lane
        digit_serial_addsub_if #(.WIDTH(16)) bus ();
        assign bus.in_valid  = drv_iv[g];
        assign bus.a         = drv_a[g];
        assign bus.b         = drv_b[g];
        assign bus.op        = drv_op[g];
        assign bus.cin       = drv_cin[g];
        assign bus.out_ready = drv_ordy[g];
        assign m_ir[g]  = bus.in_ready;
        assign m_ov[g]  = bus.out_valid;
        assign m_sum[g] = bus.sum;
        assign m_co[g]  = bus.cout;
        assign m_of[g]  = bus.overflow;
        assign m_z[g]   = bus.zero;
        digit_serial_addsub #(.WIDTH(16), .DIGIT(DIG[g])) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    function automatic int ndig(input int g);
        return 16 / DIG[g];
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic op, input logic cin, input int acc);
        exp_t e;
        int ua, ub, sa, sbv, ur, sr;
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (op) begin
            ur = ua - ub - int'(cin);
            sr = sa - sbv - int'(cin);
            e.cout = (ur >= 0);
        end else begin
            ur = ua + ub + int'(cin);
            sr = sa + sbv + int'(cin);
            e.cout = (ur > 65535);
        end
        e.overflow = (sr > 32767) || (sr < -32768);
        e.sum = 16'(ur);
`ifdef DIGIT_SERIAL_ADDSUB_SATURATE_EN
        if (e.overflow) e.sum = (sr < 0) ? 16'h8000 : 16'h7FFF;
`endif
        e.zero = (e.sum == 16'h0000);
        e.acc  = acc;
        return e;
    endfunction

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s lane%0d (DIGIT=%0d) t=%0t: got 0x%0h, expected 0x%0h",
                     name, g, DIG[g], $time, act, exp);
        end
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'hFFFF;
            4:       return 16'($urandom_range(0, 3));
            default: return 16'($urandom);
        endcase
    endfunction

    // Offer one operand bundle (called at a negedge) and record its expected result on accept.
    task automatic issue(input int g, input logic [15:0] a, input logic [15:0] b,
                         input logic op, input logic cin, input bit rnd);
        int n = 0;
        drv_a[g] = a; drv_b[g] = b; drv_op[g] = op; drv_cin[g] = cin; drv_iv[g] = 1'b1;
        while (!m_ir[g] && n < 400) begin
            @(negedge clk);
            if (rnd) drv_ordy[g] = ($urandom_range(0, 3) != 0);
            n++;
        end
        chk("accept_wait", g, 32'(m_ir[g]), 32'd1);
        sb[g].push_back(model(a, b, op, cin, cyc + 1));
        @(negedge clk);
        drv_iv[g] = 1'b0;
        drv_a[g] = 16'($urandom); drv_b[g] = 16'($urandom); drv_op[g] = 1'($urandom);
    endtask

    task automatic drain(input int g);
        int n = 0;
        drv_ordy[g] = 1'b1;
        while (sb[g].size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain", g, 32'(sb[g].size()), 32'd0);
    endtask

    task automatic run_lane(input int g);
        int n;
        drv_ordy[g] = 1'b1;
        issue(g, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0);
        issue(g, 16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0);
        issue(g, 16'h0005, 16'h0005, 1'b1, 1'b0, 1'b0);
        issue(g, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        issue(g, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
        issue(g, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0);
        issue(g, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
        drain(g);
        // Backpressure: result held in DONE while junk operands are offered.
        drv_ordy[g] = 1'b0;
        issue(g, 16'h4321, 16'h1111, 1'b0, 1'b1, 1'b0);
        n = 0;
        while (!m_ov[g] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid", g, 32'(m_ov[g]), 32'd1);
        repeat (5) begin
            drv_iv[g] = 1'b1;
            drv_a[g]  = 16'($urandom);
            @(negedge clk);
            chk("bp_in_ready", g, 32'(m_ir[g]), 32'd0);
            chk("bp_hold_valid", g, 32'(m_ov[g]), 32'd1);
        end
        drv_iv[g]   = 1'b0;
        drv_ordy[g] = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", g, 32'(m_ir[g]), 32'd1);
        chk("bp_release_valid", g, 32'(m_ov[g]), 32'd0);
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                drv_ordy[g] = ($urandom_range(0, 3) != 0);
            end
            issue(g, pick(), pick(), 1'($urandom), 1'($urandom), 1'b1);
        end
        drain(g);
    endtask

    // Monitor: compare every presented result with the scoreboard head; pop on handshake.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (rst_n) begin
            for (int g = 0; g < NL; g++) begin
                if (m_ov[g] && sb[g].size() == 0) begin
                    chk("spurious_out_valid", g, 32'(m_ov[g]), 32'd0);
                end else if (m_ov[g]) begin
                    e = sb[g][0];
                    chk("sum", g, 32'(m_sum[g]), 32'(e.sum));
                    chk("cout", g, 32'(m_co[g]), 32'(e.cout));
                    chk("overflow", g, 32'(m_of[g]), 32'(e.overflow));
                    chk("zero", g, 32'(m_z[g]), 32'(e.zero));
                    chk("in_ready_with_valid", g, 32'(m_ir[g]), 32'd0);
                    if (!seen[g]) begin
                        chk("latency", g, 32'(cyc - e.acc), 32'(ndig(g)));
                        seen[g] = 1'b1;
                    end
                    if (drv_ordy[g]) begin
                        void'(sb[g].pop_front());
                        seen[g] = 1'b0;
                    end
                end
            end
        end else begin
            seen = '0;
        end
    end

    task automatic chk_reset_state(input string tag);
        for (int g = 0; g < NL; g++) begin
            chk({tag, "_out_valid"}, g, 32'(m_ov[g]), 32'd0);
            chk({tag, "_in_ready"}, g, 32'(m_ir[g]), 32'd1);
            chk({tag, "_sum"}, g, 32'(m_sum[g]), 32'd0);
            chk({tag, "_cout"}, g, 32'(m_co[g]), 32'd0);
            chk({tag, "_overflow"}, g, 32'(m_of[g]), 32'd0);
            chk({tag, "_zero"}, g, 32'(m_z[g]), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        drv_iv = '0; drv_op = '0; drv_cin = '0; drv_ordy = '0; seen = '0;
        for (int g = 0; g < NL; g++) begin
            drv_a[g] = 16'h0000;
            drv_b[g] = 16'h0000;
        end
        #1 rst_n = 1'b0;
        #10;
        chk_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fork
            run_lane(0);
            run_lane(1);
            run_lane(2);
        join

        // Reset dropped during the second RUN cycle must discard the operation.
        @(negedge clk);
        for (int g = 0; g < NL; g++) begin
            chk("rst_pre_ready", g, 32'(m_ir[g]), 32'd1);
            drv_ordy[g] = 1'b0;
            drv_a[g] = 16'h1111; drv_b[g] = 16'h2222; drv_op[g] = 1'b0; drv_cin[g] = 1'b0;
            drv_iv[g] = 1'b1;
        end
        @(posedge clk);
        #1 drv_iv = '0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_state("midrun_reset");
        repeat (3) begin
            @(negedge clk);
            for (int g = 0; g < NL; g++) chk("reset_hold_valid", g, 32'(m_ov[g]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int g = 0; g < NL; g++) drv_ordy[g] = 1'b1;
        fork
            issue(0, 16'hABCD, 16'h1234, 1'b1, 1'b1, 1'b0);
            issue(1, 16'h7FF0, 16'h0020, 1'b0, 1'b0, 1'b0);
            issue(2, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        join
        fork
            drain(0);
            drain(1);
            drain(2);
        join
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
